counter_run_ctrl: RTL and testbench

Parametrised modulo counter with an internal run/idle state machine, pause gating, up/down direction, parallel load and a terminal-count pulse. It is the self-contained successor to the separate set/reset trigger plus enable counter arrangement: start, stop and pause requests drive it directly, and it reports its own activity. It sits beside timing and sequencing logic that needs a controllable tick counter.

---
 rtl/counter_run_pkg.sv | 18 +
 rtl/run_fsm.sv | 54 +++++
 rtl/counter_run_ctrl.sv | 77 +++++++
 tb/tb_counter_run_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/counter_run_pkg.sv
// Shared types and elaboration helpers for counter_run_ctrl and run_fsm.
// The DONE state is only reachable when COUNTER_RUN_ONESHOT_EN is defined.
package counter_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    localparam int MIN_MODULO = 2;

    // True when a MODULO-1 terminal value is representable in n bits.
    function automatic bit modulo_legal(input int n, input longint modulo);
        return (modulo >= longint'(MIN_MODULO)) && (modulo <= (longint'(1) << n));
    endfunction

endpackage

// File: rtl/run_fsm.sv
// Run/idle state machine for counter_run_ctrl; active mirrors the RUN state.
// COUNTER_RUN_ONESHOT_EN adds a DONE state entered on a counter wrap.
module run_fsm
    import counter_run_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic start,
    input  logic stop,
    input  logic wrap,
    output logic active
);

    run_state_t state_q, state_d;
    logic       active_q, active_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!load) begin
            unique case (state_q)
                IDLE, DONE: if (start && !stop) state_d = RUN;
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (wrap) begin
`ifdef COUNTER_RUN_ONESHOT_EN
                        state_d = DONE;
`else
                        state_d = RUN;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        active_d = (state_d == RUN);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/counter_run_ctrl.sv
// Modulo up/down counter with run/idle control, pause, load and terminal-count pulse.
// Define COUNTER_RUN_ONESHOT_EN to stop in DONE after the first wrap.
module counter_run_ctrl
    import counter_run_pkg::*;
#(
    parameter int N      = 4,
    parameter int MODULO = 2 ** N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic         active,
    output logic [N-1:0] counter,
    output logic         tc
);

    if (!modulo_legal(N, longint'(MODULO))) begin : g_bad_modulo
        $error("counter_run_ctrl: MODULO must lie in 2..2**N");
    end

    localparam logic [N-1:0] MAX_COUNT = N'(MODULO - 1);

    logic [N-1:0] counter_q, counter_d;
    logic         tc_q, tc_d;
    logic         running;
    logic         count_en;
    logic         wrap;
    logic [N-1:0] load_sat;

    run_fsm u_run_fsm (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .start  (start),
        .stop   (stop),
        .wrap   (wrap),
        .active (running)
    );

    // Steps happen only from RUN, and load or stop on the same edge freezes the count.
    assign count_en = running && !load && !stop && !pause;
    assign wrap     = count_en && (dir ? (counter_q == '0) : (counter_q == MAX_COUNT));
    assign load_sat = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

    always_comb begin
        counter_d = counter_q;
        tc_d      = 1'b0;
        if (load) begin
            counter_d = load_sat;
        end else if (wrap) begin
            counter_d = dir ? MAX_COUNT : '0;
            tc_d      = 1'b1;
        end else if (count_en) begin
            counter_d = dir ? (counter_q - 1'b1) : (counter_q + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_q <= '0;
            tc_q      <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tc_q      <= tc_d;
        end
    end

    assign active  = running;
    assign counter = counter_q;
    assign tc      = tc_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl (N=4, MODULO=10) with a reference model feeding a scoreboard.
// Targets the default build; the model also follows COUNTER_RUN_ONESHOT_EN when defined.
module tb_counter_run_ctrl;

    localparam int N      = 4;
    localparam int MODULO = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic         pause;
    logic         dir;
    logic         load;
    logic [N-1:0] load_value;
    logic         active;
    logic [N-1:0] counter;
    logic         tc;

    counter_run_ctrl #(.N(N), .MODULO(MODULO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .active     (active),
        .counter    (counter),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         active;
        logic [N-1:0] counter;
        logic         tc;
        string        tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    logic m_run = 1'b0;
    int   m_cnt = 0;
    logic m_tc  = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Behavioural reference of one clock edge, written from the operating rules.
    task automatic model_edge(input logic r, input logic s, input logic p, input logic pa,
                              input logic d, input logic l, input logic [N-1:0] lv);
        if (!r) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_tc  = 1'b0;
        end else if (l) begin
            m_cnt = (int'(lv) >= MODULO) ? MODULO - 1 : int'(lv);
            m_tc  = 1'b0;
        end else if (m_run && p) begin
            m_run = 1'b0;
            m_tc  = 1'b0;
        end else if (!m_run) begin
            if (s && !p) m_run = 1'b1;
            m_tc = 1'b0;
        end else if (pa) begin
            m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (d) begin
                if (m_cnt == 0) begin
                    m_cnt = MODULO - 1;
                    m_tc  = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else begin
                if (m_cnt == MODULO - 1) begin
                    m_cnt = 0;
                    m_tc  = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
`ifdef COUNTER_RUN_ONESHOT_EN
            if (m_tc) m_run = 1'b0;
`endif
        end
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic p,
                        input logic pa, input logic d, input logic l, input logic [N-1:0] lv);
        exp_t e;
        reset      = r;
        start      = s;
        stop       = p;
        pause      = pa;
        dir        = d;
        load       = l;
        load_value = lv;
        model_edge(r, s, p, pa, d, l, lv);
        e.active  = m_run;
        e.counter = m_cnt[N-1:0];
        e.tc      = m_tc;
        e.tag     = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".active"},  {7'd0, active},  {7'd0, e.active});
        check({e.tag, ".counter"}, {4'd0, counter}, {4'd0, e.counter});
        check({e.tag, ".tc"},      {7'd0, tc},      {7'd0, e.tc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Edges 1-2: reset low; load on edge 1 must not disturb the counter.
        step("rst_e1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        step("rst_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("reset_active",  {7'd0, active}, 8'd0);
        check("reset_counter", {4'd0, counter}, 8'd0);
        check("reset_tc",      {7'd0, tc}, 8'd0);
        // Edges 3-4: idle, pause and dir ignored.
        step("idle_e3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step("idle_e4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("start_e5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("start_active", {7'd0, active}, 8'd1);
        check("start_nocount", {4'd0, counter}, 8'd0);
        step("count_e6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("first_count", {4'd0, counter}, 8'd1);
        for (int i = 7; i <= 14; i++)
            step($sformatf("count_e%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("e14_counter", {4'd0, counter}, 8'd9);
        check("e14_tc",      {7'd0, tc}, 8'd0);
        step("wrap_e15", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("wrap_counter", {4'd0, counter}, 8'd0);
        check("wrap_tc",      {7'd0, tc}, 8'd1);
`ifdef COUNTER_RUN_ONESHOT_EN
        check("oneshot_active", {7'd0, active}, 8'd0);
        step("oneshot_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("oneshot_counter", {4'd0, counter}, 8'd0);
`else
        // Ten edges with two paused: count lags by 2.
        for (int i = 0; i < 10; i++)
            step($sformatf("pause_%0d", i), 1'b1, 1'b0, 1'b0, logic'(i == 2 || i == 7),
                 1'b0, 1'b0, 4'd0);
        check("pause_lag", {4'd0, counter}, 8'd8);
        step("up_to_9", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("up_to_0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("down_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("down_wrap_counter", {4'd0, counter}, 8'd9);
        check("down_wrap_tc",      {7'd0, tc}, 8'd1);
        step("down_step", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("down_step_counter", {4'd0, counter}, 8'd8);
        check("down_step_tc",      {7'd0, tc}, 8'd0);
        step("load_sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
        check("load_sat_counter", {4'd0, counter}, 8'd9);
        check("load_sat_tc",      {7'd0, tc}, 8'd0);
        check("load_sat_active",  {7'd0, active}, 8'd1);
        step("load_stop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        check("load_stop_counter", {4'd0, counter}, 8'd3);
        check("load_stop_active",  {7'd0, active}, 8'd1);
        for (int i = 0; i < 3; i++)
            step($sformatf("to6_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("stop_at6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("stop_active",  {7'd0, active}, 8'd0);
        check("stop_counter", {4'd0, counter}, 8'd6);
        step("idle_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("start_stop", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("start_stop_active", {7'd0, active}, 8'd0);
        step("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("resume_counter", {4'd0, counter}, 8'd7);
        step("rst_mid_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
        check("rst_mid_active",  {7'd0, active}, 8'd0);
        check("rst_mid_counter", {4'd0, counter}, 8'd0);
        check("rst_mid_tc",      {7'd0, tc}, 8'd0);
`endif
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
